// File: rtl/io_line_accum_pkg.sv
// io_line_accum_pkg: mode encodings, control register offsets and the combine operator
package io_line_accum_pkg;
  typedef enum logic [1:0] {MODE_COPY, MODE_XOR, MODE_ADD, MODE_OR} mode_e;
  localparam logic [15:0] OFF_PUSH = 16'h0000;
  localparam logic [15:0] OFF_CLR = 16'h0002;
  localparam logic [15:0] OFF_MODE = 16'h0004;
  localparam logic [15:0] OFF_PTR = 16'h0006;
  localparam logic [15:0] OFF_STATUS = 16'h0008;
  function automatic logic [15:0] combine(input mode_e m, input logic [15:0] o, input logic [15:0] d);
    return m == MODE_COPY ? d : m == MODE_XOR ? o ^ d : m == MODE_ADD ? o + d : o | d;
  endfunction
endpackage

// File: rtl/io_line_accum_dpram.sv
// line_dpram: simple dual-port RAM, one synchronous read port and one write port
module line_dpram #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/io_line_accum.sv
// io_line_accum: J1 I/O line accumulator with read-modify-write push pipeline and read window
module io_line_accum
  import io_line_accum_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h5000,
  parameter int DATA_W = 16,
  parameter int DEPTH = 1024,
  parameter logic [15:0] CTRL_OFF = 16'h0F00,
  parameter logic [1:0] RESET_MODE = 2'd1
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        io_hit
);
  localparam int AW = $clog2(DEPTH);
  logic [15:0] off, reg_d, reg_q;
  logic in_rng, rd, win, push, clr, mode_wr, we;
  logic [AW-1:0] ptr_q, s2_addr_q, raddr, widx;
  logic [DATA_W-1:0] s2_d_q, rdata, wdata, fwd_q;
  mode_e mode_q, s2_mode_q;
  logic wrapped_q, s2_v_q, win_q, fwd_hit_q;
  assign off = io_addr - BASE_ADDR;
  assign in_rng = io_addr[15:12] == BASE_ADDR[15:12];
  assign rd = io_rd && in_rng;
  assign win = rd && off < 16'(2 * DEPTH);
  assign widx = off[AW:1];
  assign push = io_wr && in_rng && off == CTRL_OFF + OFF_PUSH;
  assign clr = io_wr && in_rng && off == CTRL_OFF + OFF_CLR;
  assign mode_wr = io_wr && in_rng && off == CTRL_OFF + OFF_MODE;
  assign raddr = push ? ptr_q : widx;
  assign we = s2_v_q && !sys_rst_i;
  assign wdata = DATA_W'(combine(s2_mode_q, 16'(rdata), 16'(s2_d_q)));
  assign reg_d = !rd ? 16'h0000 :
                 off == CTRL_OFF + OFF_MODE ? {14'b0, mode_q} :
                 off == CTRL_OFF + OFF_PTR ? 16'(ptr_q) :
                 off == CTRL_OFF + OFF_STATUS ? {14'b0, s2_v_q, wrapped_q} : 16'h0000;
  // RAM data arrives a cycle after the address, so the window path bypasses reg_q
  assign io_din = win_q ? 16'(fwd_hit_q ? fwd_q : rdata) : reg_q;
  line_dpram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk_i(sys_clk_i),
    .we_i(we),
    .waddr_i(s2_addr_q),
    .wdata_i(wdata),
    .raddr_i(raddr),
    .rdata_o(rdata)
  );
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      ptr_q <= '0;
      wrapped_q <= 1'b0;
      mode_q <= mode_e'(RESET_MODE);
      s2_v_q <= 1'b0;
      io_hit <= 1'b0;
      win_q <= 1'b0;
      fwd_hit_q <= 1'b0;
      reg_q <= 16'h0000;
    end else begin
      io_hit <= in_rng;
      win_q <= win;
      reg_q <= reg_d;
      fwd_hit_q <= s2_v_q && win && widx == s2_addr_q;
      s2_v_q <= push;
      if (push) begin
        ptr_q <= ptr_q + 1'b1;
        wrapped_q <= wrapped_q || ptr_q == AW'(DEPTH - 1);
      end else if (clr) begin
        ptr_q <= '0;
        wrapped_q <= 1'b0;
      end
      if (mode_wr) mode_q <= mode_e'(io_dout[1:0]);
    end
  end
  always_ff @(posedge sys_clk_i) begin
    if (push) begin
      s2_addr_q <= ptr_q;
      s2_d_q <= io_dout[DATA_W-1:0];
      s2_mode_q <= mode_q;
    end
    fwd_q <= wdata;
  end
endmodule

// File: tb/tb_io_line_accum.sv
// tb_io_line_accum: random and directed bus traffic on two instances checked against a line model
module tb_io_line_accum;
  logic clk = 1'b0, rst = 1'b1, rd = 1'b0, wr = 1'b0;
  logic [15:0] addr = 16'h0000, dout = 16'h0000;
  logic [15:0] din0, din1;
  logic hit0, hit1;
  int checks = 0, errors = 0;
  bit started = 1'b0;
  int m_line[2][8];
  int m_ptr[2], m_mode[2], pa[2], pval[2];
  bit m_wrap[2], pv[2];
  logic [15:0] exp_din[2];
  logic exp_hit = 1'b0;

  always #5 clk = ~clk;

  io_line_accum #(.DEPTH(8)) u_dut (
    .sys_clk_i(clk), .sys_rst_i(rst), .io_rd(rd), .io_wr(wr),
    .io_addr(addr), .io_dout(dout), .io_din(din0), .io_hit(hit0)
  );
  io_line_accum #(.DATA_W(8), .DEPTH(4)) u_small (
    .sys_clk_i(clk), .sys_rst_i(rst), .io_rd(rd), .io_wr(wr),
    .io_addr(addr), .io_dout(dout), .io_din(din1), .io_hit(hit1)
  );

  function automatic int mdl_combine(input int m, input int o, input int d, input int msk);
    case (m)
      0: return d & msk;
      1: return (o ^ d) & msk;
      2: return (o + d) % (msk + 1);
      default: return (o | d) & msk;
    endcase
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a push is applied to the line the cycle after it is issued unless reset intervenes.
  always @(posedge clk) begin
    int dep, msk, v;
    logic [15:0] off;
    bit busy;
    for (int k = 0; k < 2; k++) begin
      dep = k == 0 ? 8 : 4;
      msk = k == 0 ? 'hFFFF : 'hFF;
      if (rst) begin
        m_ptr[k] = 0;
        m_wrap[k] = 1'b0;
        m_mode[k] = 1;
        pv[k] = 1'b0;
        exp_din[k] = 16'h0000;
      end else begin
        busy = pv[k];
        if (pv[k]) m_line[k][pa[k]] = pval[k];
        pv[k] = 1'b0;
        off = addr - 16'h5000;
        v = 0;
        if (rd && addr[15:12] == 4'h5) begin
          if (int'(off) < 2 * dep) v = m_line[k][off >> 1];
          else if (off == 16'h0F04) v = m_mode[k];
          else if (off == 16'h0F06) v = m_ptr[k];
          else if (off == 16'h0F08) v = {busy, m_wrap[k]};
        end
        exp_din[k] = 16'(v);
        if (wr && addr[15:12] == 4'h5) begin
          if (off == 16'h0F00) begin
            pa[k] = m_ptr[k];
            pval[k] = mdl_combine(m_mode[k], m_line[k][m_ptr[k]], int'(dout), msk);
            pv[k] = 1'b1;
            if (m_ptr[k] == dep - 1) m_wrap[k] = 1'b1;
            m_ptr[k] = (m_ptr[k] + 1) % dep;
          end else if (off == 16'h0F02) begin
            m_ptr[k] = 0;
            m_wrap[k] = 1'b0;
          end else if (off == 16'h0F04) m_mode[k] = int'(dout[1:0]);
        end
      end
    end
    exp_hit = !rst && addr[15:12] == 4'h5;
    if (rst) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("din_main", din0, exp_din[0]);
      check("din_small", din1, exp_din[1]);
      check("hit_main", {15'b0, hit0}, {15'b0, exp_hit});
      check("hit_small", {15'b0, hit1}, {15'b0, exp_hit});
    end
  end

  task automatic drive(input logic r, input logic rdv, input logic wrv, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    rst = r; rd = rdv; wr = wrv; addr = a; dout = d;
  endtask

  task automatic wreg(input logic [15:0] o, input logic [15:0] d);
    drive(1'b0, 1'b0, 1'b1, 16'h5F00 + o, d);
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] a, input logic [15:0] e0, input logic [15:0] e1);
    drive(1'b0, 1'b1, 1'b0, a, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check({nm, "_main"}, din0, e0);
    check({nm, "_small"}, din1, e1);
    check({nm, "_hit"}, {15'b0, hit0}, 16'h0001);
  endtask

  initial begin
    logic [15:0] a;
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rd_chk("rst_mode", 16'h5F04, 16'h0001, 16'h0001);
    rd_chk("rst_ptr", 16'h5F06, 16'h0000, 16'h0000);
    rd_chk("rst_status", 16'h5F08, 16'h0000, 16'h0000);
    wreg(16'h4, 16'h0000);
    wreg(16'h2, 16'h0000);
    for (int i = 0; i < 8; i++) wreg(16'h0, 16'h0000);
    wreg(16'h4, 16'h0001);
    wreg(16'h2, 16'h0000);
    wreg(16'h0, 16'h00FF);
    wreg(16'h2, 16'h0000);
    wreg(16'h0, 16'h0F0F);
    rd_chk("xor_w0", 16'h5000, 16'h0FF0, 16'h00F0);
    rd_chk("xor_ptr", 16'h5F06, 16'h0001, 16'h0001);
    wreg(16'h4, 16'h0000);
    wreg(16'h2, 16'h0000);
    wreg(16'h0, 16'h0000);
    wreg(16'h4, 16'h0002);
    wreg(16'h2, 16'h0000);
    wreg(16'h0, 16'h00F0);
    wreg(16'h2, 16'h0000);
    wreg(16'h0, 16'h0020);
    rd_chk("add_w0", 16'h5000, 16'h0110, 16'h0010);
    wreg(16'h4, 16'h0000);
    wreg(16'h2, 16'h0000);
    for (int i = 1; i <= 5; i++) wreg(16'h0, 16'(i * 'h11));
    rd_chk("wrap_ptr", 16'h5F06, 16'h0005, 16'h0001);
    rd_chk("wrap_status", 16'h5F08, 16'h0000, 16'h0001);
    rd_chk("wrap_w0", 16'h5000, 16'h0011, 16'h0055);
    wreg(16'h2, 16'h0000);
    wreg(16'h0, 16'h1234);
    rd_chk("fwd_w0", 16'h5000, 16'h1234, 16'h0034);
    wreg(16'h2, 16'h0000);
    wreg(16'h0, 16'hABCD);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rd_chk("rst_supp_w0", 16'h5000, 16'h1234, 16'h0034);
    wreg(16'h2, 16'h0000);
    wreg(16'h0, 16'h0F0F);
    wreg(16'h4, 16'h0002);
    wreg(16'h0, 16'h0001);
    rd_chk("mode_old_w0", 16'h5000, 16'h1D3B, 16'h003B);
    rd_chk("mode_new_w1", 16'h5002, 16'h0023, 16'h0023);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if ($urandom_range(0, 199) == 0) drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      else if (r <= 2) wreg(16'h0, 16'($urandom));
      else if (r == 3) wreg(16'h2, 16'($urandom));
      else if (r == 4) wreg(16'h4, 16'($urandom));
      else if (r <= 6) drive(1'b0, 1'b1, 1'b0, 16'h5000 + 16'($urandom_range(0, 19)), 16'h0000);
      else if (r == 7) drive(1'b0, 1'b1, 1'b0, 16'h5F00 + 16'($urandom_range(0, 11)), 16'h0000);
      else if (r == 8) begin
        a = $urandom_range(0, 1) ? 16'h5000 + 16'($urandom_range(0, 15)) : 16'h5F0A;
        drive(1'b0, 1'b0, 1'b1, a, 16'($urandom));
      end else drive(1'b0, $urandom_range(0, 1) == 1, 1'b0, 16'($urandom_range(0, 16'h4FFF)), 16'h0000);
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
